// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signals of the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [CNT_WIDTH-1:0]          wr_count;

  modport master (
    output req, req_data, wfull,
    input  gnt, ack, winc, wdata, wr_count
  );

  modport slave (
    input  req, req_data, wfull,
    output gnt, ack, winc, wdata, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
// Grants up to BURST_LEN words per owner, then rotates; never writes while wfull.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last;
  logic [CW-1:0]          burst_cnt;
  logic [NUM_REQ-1:0]     gnt;
  logic [CNT_WIDTH-1:0]   wr_count;

  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic                   write;
  logic [DATA_WIDTH-1:0]  words [NUM_REQ];

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign write        = (state == BURST) && bus.req[owner] && !bus.wfull;
  assign bus.winc     = write;
  assign bus.wdata    = (state == BURST) ? words[owner] : '0;
  assign bus.ack      = write ? (NUM_REQ'(1) << owner) : '0;
  assign bus.gnt      = gnt;
  assign bus.wr_count = wr_count;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      gnt       <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner     <= pick;
            gnt       <= NUM_REQ'(1) << pick;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (write) begin
            wr_count  <= wr_count + CNT_WIDTH'(1);
            burst_cnt <= burst_cnt + CW'(1);
            if (burst_cnt == CW'(BURST_LEN - 1)) begin
              state <= IDLE;
              gnt   <= '0;
              last  <= owner;
            end
          end else if (!bus.req[owner]) begin
            // Requester withdrew; a full FIFO alone only stalls the burst.
            state <= IDLE;
            gnt   <= '0;
            last  <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  no_write_when_full: assert property (@(posedge wclk) disable iff (!wrst_n)
    !(bus.winc && bus.wfull));
endmodule
